// File: rtl/tl_pkg.sv
// Shared lamp codes, phase encoding and defaults for the traffic light monitor.
package tl_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int GREEN_DEF  = 6;
  localparam int YELLOW_DEF = 3;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2,
    PH_D = 2'd3
  } phase_t;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Combinational NS/EW lamp-pair decoder.
module tl_phase_decode
  import tl_pkg::*;
(
  input  logic [2:0] ns,
  input  logic [2:0] ew,
  output phase_t     phase,
  output logic       legal
);

  always_comb begin
    phase = PH_A;
    legal = 1'b1;
    unique case (1'b1)
      (ns == GREEN  && ew == RED):    phase = PH_A;
      (ns == YELLOW && ew == RED):    phase = PH_B;
      (ns == RED    && ew == GREEN):  phase = PH_C;
      (ns == RED    && ew == YELLOW): phase = PH_D;
      default:                        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence/timing monitor with registered outputs.
// Timing checks are built only when TL_MON_TIMING_EN is defined.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_CYCLES  = GREEN_DEF,
  parameter int YELLOW_CYCLES = YELLOW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] NS,
  input  logic [2:0] EW,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic [7:0] dur,
  output logic       err_illegal,
  output logic       err_seq,
  output logic       err_timing,
  output logic [7:0] err_count
);

  phase_t     in_phase;
  logic       in_legal;
  mon_state_t state_q, state_d;
  phase_t     phase_q, phase_d;
  logic       valid_q, valid_d;
  logic [7:0] dur_q, dur_d;
  logic       ill_q, ill_d;
  logic       seq_q, seq_d;
  logic       tim_q, tim_d;
  logic [7:0] cnt_q, cnt_d;

  tl_phase_decode u_dec (
    .ns    (NS),
    .ew    (EW),
    .phase (in_phase),
    .legal (in_legal)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    valid_d = valid_q;
    dur_d   = dur_q;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    if (!in_legal) begin
      ill_d   = 1'b1;
      valid_d = 1'b0;
      dur_d   = 8'd0;
      state_d = SYNC;
    end else begin
      unique case (state_q)
        SYNC: begin
          phase_d = in_phase;
          valid_d = 1'b1;
          dur_d   = 8'd1;
          state_d = TRACK;
        end
        TRACK: begin
          if (in_phase == phase_q) begin
            if (dur_q != 8'hFF) dur_d = dur_q + 8'd1;
          end else begin
            seq_d   = (in_phase != next_phase(phase_q));
            phase_d = in_phase;
            dur_d   = 8'd1;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

`ifdef TL_MON_TIMING_EN
  // exempt: phase start not observed; over: overstay already reported
  logic       exempt_q, exempt_d;
  logic       over_q, over_d;
  logic [7:0] exp_len;

  always_comb begin
    exp_len  = (phase_q == PH_A || phase_q == PH_C)
             ? 8'(GREEN_CYCLES) : 8'(YELLOW_CYCLES);
    tim_d    = 1'b0;
    exempt_d = exempt_q;
    over_d   = over_q;
    if (in_legal) begin
      if (state_q == SYNC) begin
        exempt_d = 1'b1;
        over_d   = 1'b0;
      end else if (in_phase == phase_q) begin
        if (!exempt_q && !over_q && dur_q == exp_len) begin
          tim_d  = 1'b1;
          over_d = 1'b1;
        end
      end else begin
        tim_d    = !exempt_q && !over_q && (dur_q < exp_len);
        exempt_d = 1'b0;
        over_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exempt_q <= 1'b1;
      over_q   <= 1'b0;
    end else begin
      exempt_q <= exempt_d;
      over_q   <= over_d;
    end
  end
`else
  assign tim_d = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if ((ill_d || seq_d || tim_d) && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      phase_q <= PH_A;
      valid_q <= 1'b0;
      dur_q   <= 8'd0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      tim_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      dur_q   <= dur_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      tim_q   <= tim_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign dur         = dur_q;
  assign err_illegal = ill_q;
  assign err_seq     = seq_q;
  assign err_timing  = tim_q;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: vector table, corner sequences, random vs model.
module tb_traffic_light_monitor;

  localparam int G_LEN = 6;
  localparam int Y_LEN = 3;
`ifdef TL_MON_TIMING_EN
  localparam int TIM_ON = 1;
`else
  localparam int TIM_ON = 0;
`endif

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] NS = 3'b000;
  logic [2:0] EW = 3'b000;
  logic [1:0] phase;
  logic       phase_valid;
  logic [7:0] dur;
  logic       err_illegal;
  logic       err_seq;
  logic       err_timing;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  traffic_light_monitor #(
    .GREEN_CYCLES  (G_LEN),
    .YELLOW_CYCLES (Y_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .NS          (NS),
    .EW          (EW),
    .phase       (phase),
    .phase_valid (phase_valid),
    .dur         (dur),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_timing  (err_timing),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  logic [2:0] pair_ns [4];
  logic [2:0] pair_ew [4];

  // reference model state: the run of identical legal inputs
  bit m_sync, m_obs, m_valid, m_ill, m_seq, m_tim;
  int m_ph, m_run, m_cnt;

  function automatic int exp_len(input int p);
    return (p == 0 || p == 2) ? G_LEN : Y_LEN;
  endfunction

  function automatic int lookup(input logic [2:0] ns, input logic [2:0] ew);
    for (int i = 0; i < 4; i++)
      if (pair_ns[i] == ns && pair_ew[i] == ew) return i;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] ns,
                            input logic [2:0] ew);
    int p;
    m_ill = 0; m_seq = 0; m_tim = 0;
    if (r) begin
      m_sync = 1; m_ph = 0; m_valid = 0; m_run = 0; m_cnt = 0;
      return;
    end
    p = lookup(ns, ew);
    if (p < 0) begin
      m_ill = 1; m_valid = 0; m_run = 0; m_sync = 1;
    end else if (m_sync) begin
      m_ph = p; m_run = 1; m_valid = 1; m_obs = 0; m_sync = 0;
    end else if (p == m_ph) begin
      m_run++;
      if (TIM_ON != 0 && m_obs && m_run == exp_len(p) + 1) m_tim = 1;
    end else begin
      m_seq = (p != (m_ph + 1) % 4);
      if (TIM_ON != 0 && m_obs && m_run < exp_len(m_ph)) m_tim = 1;
      m_ph = p; m_run = 1; m_obs = 1;
    end
    if ((m_ill || m_seq || m_tim) && m_cnt < 255) m_cnt++;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] ns, input logic [2:0] ew);
    rst = r; NS = ns; EW = ew;
    model_step(r, ns, ew);
    @(posedge clk);
    #1;
    chk("m_phase", phase, m_ph);
    chk("m_valid", phase_valid, m_valid);
    chk("m_dur", dur, (m_run > 255) ? 255 : m_run);
    chk("m_ill", err_illegal, m_ill);
    chk("m_seq", err_seq, m_seq);
    chk("m_tim", err_timing, m_tim);
    chk("m_cnt", err_count, m_cnt);
  endtask

  task automatic drive(input int p, input int n);
    for (int i = 0; i < n; i++) step(1'b0, pair_ns[p], pair_ew[p]);
  endtask

  typedef struct {
    logic       r;
    logic [2:0] ns;
    logic [2:0] ew;
    int ph, vld, dr, ill, seq, cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] ns, input logic [2:0] ew,
                     input int n, input int ph, input int vld, input int d0,
                     input int ill, input int seq, input int cnt);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.r = r; v.ns = ns; v.ew = ew; v.ph = ph; v.vld = vld;
      v.dr = (d0 == 0) ? 0 : d0 + i;
      v.ill = ill; v.seq = (i == 0) ? seq : 0; v.cnt = cnt;
      tbl.push_back(v);
    end
  endtask

  initial begin
    int last;
    int r;
    pair_ns[0] = LG; pair_ew[0] = LR;
    pair_ns[1] = LY; pair_ew[1] = LR;
    pair_ns[2] = LR; pair_ew[2] = LG;
    pair_ns[3] = LR; pair_ew[3] = LY;
    m_sync = 1; m_obs = 0; m_valid = 0; m_ph = 0; m_run = 0; m_cnt = 0;

    add(1, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    add(0, LG, LR, 6, 0, 1, 1, 0, 0, 0);
    add(0, LY, LR, 3, 1, 1, 1, 0, 0, 0);
    add(0, LR, LG, 6, 2, 1, 1, 0, 0, 0);
    add(0, LR, LY, 3, 3, 1, 1, 0, 0, 0);
    add(0, LG, LR, 6, 0, 1, 1, 0, 0, 0);
    add(0, LR, LG, 1, 2, 1, 1, 0, 1, 1);
    add(1, LR, LG, 1, 0, 0, 0, 0, 0, 0);
    add(0, LG, LR, 6, 0, 1, 1, 0, 0, 0);
    add(0, LG, LG, 1, 0, 0, 0, 1, 0, 1);
    add(0, LR, LR, 1, 0, 0, 0, 1, 0, 2);
    add(0, 3'b000, 3'b000, 1, 0, 0, 0, 1, 0, 3);
    add(0, LR, LY, 1, 3, 1, 1, 0, 0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].ns, tbl[i].ew);
      chk("tbl_phase", phase, tbl[i].ph);
      chk("tbl_valid", phase_valid, tbl[i].vld);
      chk("tbl_dur", dur, tbl[i].dr);
      chk("tbl_ill", err_illegal, tbl[i].ill);
      chk("tbl_seq", err_seq, tbl[i].seq);
      chk("tbl_tim", err_timing, 0);
      chk("tbl_cnt", err_count, tbl[i].cnt);
    end

    // overstay and early exit on TRACK-entered phases
    step(1'b1, LR, LR);
    drive(3, 1);
    drive(0, 6);
    drive(1, 3);
    chk("b_ovr_c3", err_timing, 0);
    drive(1, 1);
    chk("b_ovr_c4", err_timing, TIM_ON);
    chk("b_ovr_cnt", err_count, TIM_ON);
    drive(1, 1);
    chk("b_ovr_c5", err_timing, 0);
    chk("b_ovr_dur", dur, 5);
    drive(2, 1);
    chk("b_ovr_exit", err_timing, 0);
    chk("b_ovr_seq", err_seq, 0);
    drive(2, 5);
    drive(3, 2);
    drive(0, 1);
    chk("d_early", err_timing, TIM_ON);
    chk("d_early_cnt", err_count, 2 * TIM_ON);
    drive(0, 5);
    drive(1, 2);
    chk("b_short_hold", err_timing, 0);
    drive(2, 1);
    chk("b_early", err_timing, TIM_ON);
    chk("b_early_cnt", err_count, 3 * TIM_ON);

    // reset in the middle of C, then D accepted as a fresh start
    drive(2, 3);
    step(1'b1, LR, LG);
    chk("rst_phase", phase, 0);
    chk("rst_valid", phase_valid, 0);
    chk("rst_dur", dur, 0);
    chk("rst_cnt", err_count, 0);
    drive(3, 1);
    chk("post_rst_phase", phase, 3);
    chk("post_rst_dur", dur, 1);
    chk("post_rst_seq", err_seq, 0);
    chk("post_rst_tim", err_timing, 0);
    drive(3, 1);
    drive(0, 1);
    chk("post_rst_exempt", err_timing, 0);

    // error counter saturation
    step(1'b1, LR, LR);
    for (int i = 0; i < 300; i++) step(1'b0, LR, LR);
    chk("cnt_sat", err_count, 255);
    step(1'b0, LG, LG);
    chk("cnt_nowrap", err_count, 255);

    // random stimulus against the model
    step(1'b1, LR, LR);
    last = 0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, pair_ns[last], pair_ew[last]);
      end else if (r < 8) begin
        step(1'b0, 3'($urandom), 3'($urandom));
      end else if (r < 18) begin
        last = $urandom_range(0, 3);
        drive(last, 1);
      end else if (r < 35) begin
        last = (last + 1) % 4;
        drive(last, 1);
      end else begin
        drive(last, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have the parameter GREEN_CYCLES, default 6, giving the required green-phase length in cycles.
REQ-002 The block SHALL have the parameter YELLOW_CYCLES, default 3, giving the required yellow-phase length in cycles.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port NS, input, 3 bits: north-south lamp code, one-hot, 100=red, 010=yellow, 001=green.
REQ-006 The block SHALL have the port EW, input, 3 bits: east-west lamp code, with the same encoding as NS.
REQ-007 The block SHALL have the port phase, output, 2 bits: decoded phase, A=0, B=1, C=2, D=3.
REQ-008 The block SHALL have the port phase_valid, output, 1 bit: high when phase holds a decoded legal phase.
REQ-009 The block SHALL have the port dur, output, 8 bits: cycles observed in the current phase, including the current cycle; saturates at 255.
REQ-010 The block SHALL have the port err_illegal, output, 1 bit: one-cycle pulse when the NS/EW pair is not a legal combination.
REQ-011 The block SHALL have the port err_seq, output, 1 bit: one-cycle pulse on an out-of-order phase change.
REQ-012 The block SHALL have the port err_timing, output, 1 bit: one-cycle pulse on a phase-length violation.
REQ-013 The block SHALL have the port err_count, output, 8 bits: saturating count of cycles in which any error pulse is asserted.

Function
REQ-014 The legal lamp pairs SHALL be decoded as follows: A = NS 001 / EW 100; B = NS 010 / EW 100; C = NS 100 / EW 001; D = NS 100 / EW 010. Every other pair, including all-red and all-off, is illegal.
REQ-015 All outputs SHALL be registered: inputs present before rising edge N are reflected in the outputs after edge N, a latency of one cycle.
REQ-016 The monitor FSM SHALL have two states: SYNC (no trusted phase held) and TRACK (a phase is held).
REQ-017 In SYNC, on a legal input the block SHALL load phase, set phase_valid=1, set dur=1, and go to TRACK, with no sequence or timing check applied.
REQ-018 In TRACK, when the input phase equals the held phase, dur SHALL increment, saturating at 255.
REQ-019 In TRACK, on a change to the successor phase (A->B->C->D->A), the block SHALL load the new phase and set dur=1.
REQ-020 In TRACK, on a change to a non-successor legal phase, the block SHALL pulse err_seq, load the new phase, and set dur=1.
REQ-021 On any illegal input, in either state, the block SHALL pulse err_illegal, set phase_valid=0, set dur=0, and go to SYNC; phase keeps its last value.
REQ-022 The expected length SHALL be GREEN_CYCLES for phases A and C, and YELLOW_CYCLES for phases B and D.
REQ-023 Early exit: when a phase entered from TRACK (a fully observed phase) is left with dur less than the expected length, the block SHALL pulse err_timing.
REQ-024 Overstay: when dur would become expected+1, the block SHALL pulse err_timing exactly once per phase, and that phase SHALL produce no further timing error on exit.
REQ-025 A phase entered from SYNC SHALL be exempt from timing checks, because its start was not observed.
REQ-026 Simultaneous errors (err_seq with err_timing on the same edge) SHALL both pulse, and err_count SHALL increment by one only.
REQ-027 err_count SHALL saturate at 255 and never wrap.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=SYNC, phase=0, phase_valid=0, dur=0, all error pulses=0, and err_count=0.
REQ-029 Reset asserted mid-phase SHALL discard the held phase, and the first legal input after reset SHALL follow REQ-017.

Configuration
REQ-030 With TL_MON_TIMING_EN defined, the timing checks of REQ-022 to REQ-025 SHALL be present.
REQ-031 Without TL_MON_TIMING_EN, err_timing SHALL be tied to 0 and the timing-check logic SHALL be removed, while dur remains functional.

Structure
REQ-032 A shared package tl_pkg SHALL hold the lamp codes (RED, YELLOW, GREEN), the phase encoding A to D, the successor function, and the default cycle constants.
REQ-033 A combinational sub-module tl_phase_decode SHALL map NS/EW to a 2-bit phase and a legal flag.

Verification
REQ-034 The bench SHALL cover: after reset, drive A x6, B x3, C x6, D x3, A x6 -> phase follows 0,1,2,3,0 with one-cycle lag; no error pulses; err_count=0.
REQ-035 The bench SHALL cover: drive A x6, then NS=001 / EW=001 for 1 cycle -> err_illegal pulses once; phase_valid=0; dur=0; err_count=1.
REQ-036 The bench SHALL cover: after a full A x6 entered from TRACK, drive C -> err_seq pulses once; phase=2; dur=1.
REQ-037 The bench SHALL cover: with the default parameters, a TRACK-entered B held 5 cycles -> err_timing pulses on the 4th cycle only; it is also tested with a B held 2 cycles -> err_timing pulses on exit.
REQ-038 The bench SHALL cover: apply rst for 1 cycle in the middle of C -> all outputs reset; the next D is accepted without err_seq or err_timing.
REQ-039 The bench SHALL cover: force 300 illegal cycles -> err_count=255 with no wrap; the build without TL_MON_TIMING_EN is run with REQ-037 stimulus -> err_timing stays 0.
